// File: rtl/synchronous_fifo_level.sv
// Single-clock FIFO of any depth >= 2 with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow status.
// Define SYNCHRONOUS_FIFO_LEVEL_FWFT_EN for first-word-fall-through reads.
module synchronous_fifo_level #(
    parameter int dataWidth  = 8,
    parameter int depth      = 16,
    parameter int countWidth = $clog2(depth + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [dataWidth-1:0]  pushData,
    output logic                  full,
    output logic                  almostFull,
    input  logic                  pop,
    output logic [dataWidth-1:0]  popData,
    output logic                  empty,
    output logic                  almostEmpty,
    input  logic [countWidth-1:0] almostFullLevel,
    input  logic [countWidth-1:0] almostEmptyLevel,
    output logic [countWidth-1:0] count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clearStatus
);

    localparam int ptrWidth = (depth > 1) ? $clog2(depth) : 1;

    logic [dataWidth-1:0]  mem_q [depth];
    logic [ptrWidth-1:0]   wrPtr_q, wrPtr_d;
    logic [ptrWidth-1:0]   rdPtr_q, rdPtr_d;
    logic [countWidth-1:0] count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almostFull_q, almostFull_d;
    logic                  almostEmpty_q, almostEmpty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  popAccept, pushAccept;

    // Explicit wrap so non-power-of-two depths cycle through exactly depth slots.
    function automatic logic [ptrWidth-1:0] nextPtr(input logic [ptrWidth-1:0] p);
        return (p == ptrWidth'(depth - 1)) ? '0 : p + ptrWidth'(1);
    endfunction

    always_comb begin
        popAccept  = pop & ~empty_q;
        pushAccept = push & (~full_q | popAccept);

        count_d = count_q;
        unique case ({pushAccept, popAccept})
            2'b10:   count_d = count_q + countWidth'(1);
            2'b01:   count_d = count_q - countWidth'(1);
            default: count_d = count_q;
        endcase

        wrPtr_d = pushAccept ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = popAccept  ? nextPtr(rdPtr_q) : rdPtr_q;

        // Flags come from the next count so they track count cycle for cycle.
        full_d        = (count_d == countWidth'(depth));
        empty_d       = (count_d == '0);
        almostFull_d  = (count_d >= almostFullLevel);
        almostEmpty_d = (count_d <= almostEmptyLevel);

        overflow_d  = (overflow_q  & ~clearStatus) | (push & ~pushAccept);
        underflow_d = (underflow_q & ~clearStatus) | (pop  & ~popAccept);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && pushAccept) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

`ifdef SYNCHRONOUS_FIFO_LEVEL_FWFT_EN
    assign popData = mem_q[rdPtr_q];
`else
    logic [dataWidth-1:0] popData_q;

    // Non-blocking read samples the old head even when a full push+pop
    // overwrites the same slot at this edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            popData_q <= '0;
        end else if (popAccept) begin
            popData_q <= mem_q[rdPtr_q];
        end
    end

    assign popData = popData_q;
`endif

    assign full        = full_q;
    assign empty       = empty_q;
    assign almostFull  = almostFull_q;
    assign almostEmpty = almostEmpty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_synchronous_fifo_level.sv
// Randomized and directed bench for synchronous_fifo_level: depth 16 and depth 12
// instances share stimulus and are each checked against a queue-based model.
module tb_synchronous_fifo_level;

    typedef logic [7:0] q_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0, pop = 1'b0, clearStatus = 1'b0;
    logic [7:0] pushData = '0;
    int         afl = 10, ael = 2;

    logic [4:0] afl16, ael16, count16;
    logic [3:0] afl12, ael12, count12;
    logic [7:0] popData16, popData12;
    logic full16, aF16, empty16, aE16, ovf16, unf16;
    logic full12, aF12, empty12, aE12, ovf12, unf12;

    assign afl16 = 5'(afl);
    assign ael16 = 5'(ael);
    assign afl12 = 4'(afl);
    assign ael12 = 4'(ael);

    synchronous_fifo_level #(.dataWidth(8), .depth(16)) dut16 (
        .clock(clock), .reset(reset), .push(push), .pushData(pushData),
        .full(full16), .almostFull(aF16), .pop(pop), .popData(popData16),
        .empty(empty16), .almostEmpty(aE16), .almostFullLevel(afl16),
        .almostEmptyLevel(ael16), .count(count16), .overflow(ovf16),
        .underflow(unf16), .clearStatus(clearStatus)
    );

    synchronous_fifo_level #(.dataWidth(8), .depth(12)) dut12 (
        .clock(clock), .reset(reset), .push(push), .pushData(pushData),
        .full(full12), .almostFull(aF12), .pop(pop), .popData(popData12),
        .empty(empty12), .almostEmpty(aE12), .almostFullLevel(afl12),
        .almostEmptyLevel(ael12), .count(count12), .overflow(ovf12),
        .underflow(unf12), .clearStatus(clearStatus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = depth 16, index 1 = depth 12.
    q_t         q0, q1;
    logic [7:0] pd [2];
    bit         ov [2], un [2], af [2], ae [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int dep, ref q_t q);
        bit pa, wa;
        if (!reset) begin
            q.delete();
            pd[k] = 8'h00;
            ov[k] = 0; un[k] = 0; af[k] = 0; ae[k] = 1;
            return;
        end
        pa = pop && (q.size() != 0);
        wa = push && ((q.size() < dep) || pa);
        if (pa) pd[k] = q.pop_front();
        if (wa) q.push_back(pushData);
        ov[k] = (ov[k] && !clearStatus) || (push && !wa);
        un[k] = (un[k] && !clearStatus) || (pop && !pa);
        af[k] = (q.size() >= afl);
        ae[k] = (q.size() <= ael);
    endtask

    task automatic check_dut(input int k, input int dep, input int sz, input logic [7:0] head,
                             input logic [31:0] c, input logic f, input logic e,
                             input logic afo, input logic aeo, input logic ovo,
                             input logic uno, input logic [7:0] pdo);
        string p;
        p = $sformatf("d%0d ", dep);
        check({p, "count"},       c,   sz);
        check({p, "full"},        f,   (sz == dep));
        check({p, "empty"},       e,   (sz == 0));
        check({p, "almostFull"},  afo, af[k]);
        check({p, "almostEmpty"}, aeo, ae[k]);
        check({p, "overflow"},    ovo, ov[k]);
        check({p, "underflow"},   uno, un[k]);
`ifdef SYNCHRONOUS_FIFO_LEVEL_FWFT_EN
        if (sz != 0) check({p, "popData"}, pdo, head);
`else
        check({p, "popData"}, pdo, pd[k]);
`endif
    endtask

    task automatic cycle(input logic rst_n, input logic psh, input logic pp,
                         input logic clr, input logic [7:0] d);
        reset = rst_n; push = psh; pop = pp; clearStatus = clr; pushData = d;
        @(posedge clock);
        model_step(0, 16, q0);
        model_step(1, 12, q1);
        #1;
        check_dut(0, 16, q0.size(), (q0.size() != 0) ? q0[0] : 8'h00,
                  32'(count16), full16, empty16, aF16, aE16, ovf16, unf16, popData16);
        check_dut(1, 12, q1.size(), (q1.size() != 0) ? q1[0] : 8'h00,
                  32'(count12), full12, empty12, aF12, aE12, ovf12, unf12, popData12);
    endtask

    initial begin
        int bias;
        afl = 10; ael = 2;
        cycle(0, 1, 1, 0, 8'hFF);
        cycle(0, 0, 0, 0, 8'h00);

        // Fill with 0x00..0x0F, then a rejected push of 0xAA.
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 8'(i));
        check("fill full16", full16, 1'b1);
        cycle(1, 1, 0, 0, 8'hAA);
        check("push-on-full overflow16", ovf16, 1'b1);

        // Full push+pop: head leaves, 0x55 joins the tail.
        cycle(1, 1, 1, 0, 8'h55);
        check("full push+pop head16", popData16, 8'h00);

        // Drain past empty to set underflow, then clear status.
        for (int i = 0; i < 18; i++) cycle(1, 0, 1, 0, 8'h00);
        check("drain underflow16", unf16, 1'b1);
        cycle(1, 0, 0, 1, 8'h00);
        check("clear overflow16", ovf16, 1'b0);

        // Depth-12 wrap pattern.
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 8'(i));
        for (int i = 0; i < 5; i++)  cycle(1, 0, 1, 0, 8'h00);
        for (int i = 12; i < 17; i++) cycle(1, 1, 0, 0, 8'(i));
        for (int i = 0; i < 12; i++) cycle(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++)  cycle(1, 0, 1, 0, 8'h00);

        // Threshold change at count 5.
        cycle(1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 8'(8'h30 + i));
        afl = 4;
        cycle(1, 0, 0, 0, 8'h00);
        check("afl=4 at count 5 almostFull16", aF16, 1'b1);
        afl = 10;

        // Reset mid-stream at count 7, then a pop that must be rejected.
        cycle(1, 1, 0, 0, 8'h40);
        cycle(1, 1, 0, 0, 8'h41);
        cycle(0, 1, 1, 0, 8'h42);
        cycle(1, 0, 1, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h3C);
        cycle(1, 0, 0, 0, 8'h00);

        // Random traffic with drifting push/pop bias to visit full and empty.
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) bias = $urandom_range(15, 85);
            if (i % 100 == 0) begin
                afl = $urandom_range(0, 12);
                ael = $urandom_range(0, 12);
            end
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 99) < bias),
                  ($urandom_range(0, 99) >= bias),
                  ($urandom_range(0, 39) == 0),
                  8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/synchronous_fifo_level.md
Name: synchronous_fifo_level

Overview:
Single-clock FIFO, the next generation of the team's FIFO family. Generalised in depth: any depth ≥ 2, not only powers of two. Adds an occupancy count, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow status. Used wherever producer and consumer share one clock; the dual-clock FIFO remains the choice for clock-domain crossings.

Parameters:
dataWidth, 8, width of each stored word in bits
depth, 16, number of storage entries; any integer ≥ 2
countWidth, $clog2(depth+1), width of level, threshold and count fields; derived, not overridden

Ports:
clock  input  1  core clock; all logic on rising edge
reset  input  1  synchronous reset, active-low
push  input  1  write request
pushData  input  dataWidth  word to write
full  output  1  count == depth
almostFull  output  1  count >= almostFullLevel
pop  input  1  read request
popData  output  dataWidth  read word
empty  output  1  count == 0
almostEmpty  output  1  count <= almostEmptyLevel
almostFullLevel  input  countWidth  almost-full threshold, quasi-static
almostEmptyLevel  input  countWidth  almost-empty threshold, quasi-static
count  output  countWidth  current occupancy
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected
clearStatus  input  1  clears overflow/underflow

Behaviour:
- Reset (reset=0 at an edge) sets:
  - write/read pointers = 0, count = 0
  - empty = 1, full = 0, almostEmpty = 1, almostFull = 0
  - overflow = 0, underflow = 0, popData = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all contents. Requests in the reset cycle are ignored.
- Accept rules, evaluated on registered state before the edge:
  - popAccept = pop & !empty
  - pushAccept = push & (!full | popAccept): push into a full FIFO succeeds only with a simultaneous accepted pop.
  - Pop on empty is always rejected, even with a simultaneous push.
- Count update:
  - +1 on push only, −1 on pop only.
  - Unchanged when both are accepted or neither is.
  - Never exceeds depth; never wraps below 0.
- Pointers:
  - Each pointer increments on accept and wraps from depth−1 to 0 (explicit compare, no power-of-two masking).
  - full/empty are decoded from count, never from pointer equality.
- Flag timing:
  - full, empty, almostFull and almostEmpty are registered and computed from the next count, so they agree with count in every cycle.
  - A push at edge k makes empty=0 visible after edge k.
- Threshold changes take effect on the first edge after the change.
- Sticky status:
  - overflow sets on push & !pushAccept; underflow sets on pop & !popAccept.
  - Both hold until clearStatus=1.
  - If clearStatus and a new error occur in the same cycle, the set wins.
- Read path (standard mode):
  - popData is registered and updates at the edge of an accepted pop with mem[readPointer]; one-cycle read latency.
  - popData holds its value otherwise.
- Write path: mem[writePointer] <= pushData on pushAccept.
- Full-with-pop case: the pop reads the old head before the overwrite lands; read-before-write ordering is required.

Optional Feature:
Macro: SYNCHRONOUS_FIFO_LEVEL_FWFT_EN
- Defined (first-word-fall-through):
  - popData continuously presents mem[readPointer] whenever empty=0.
  - pop acknowledges and advances to the next word.
  - Data is valid in the same cycle empty deasserts.
  - popData is don't-care while empty=1.
  - Memory is implemented with asynchronous read.
- Undefined: registered one-cycle read as described under Behaviour.
- Flags, count and accept rules are identical in both modes.

Test Plan:
- Fill and drain, depth=16: push 0x00..0x0F on consecutive cycles, then pop 16 times → popData 0x00..0x0F in order; full=1 at count 16; empty=1 after the last pop; overflow=0, underflow=0.
- Non-power-of-two wrap, depth=12: push 12, pop 5, push 5, pop 12 → output 0..11 then 12..16 in order; count never exceeds 12; full asserts twice.
- Overflow/underflow: on full FIFO push 0xAA alone → count stays 16, overflow=1, 0xAA never appears. On empty FIFO pop → underflow=1. clearStatus=1 for one cycle → both flags 0.
- Simultaneous full push+pop: full FIFO holding 0..15, push 0x55 with pop → popData=0x00, count=16, and 0x55 emerges as the 16th subsequent pop.
- Thresholds: almostFullLevel=10, almostEmptyLevel=2; push to 10 → almostFull rises at count 10; pop to 2 → almostEmpty rises at count 2. Change almostFullLevel to 4 at count 5 → almostFull=1 after the next edge.
- Reset mid-stream and FWFT: at count 7, reset=0 for one cycle → count=0, empty=1, next pop rejected. With SYNCHRONOUS_FIFO_LEVEL_FWFT_EN, push 0x3C → popData=0x3C in the cycle empty=0, with no pop issued.
